// File: rtl/jtkcpu_simctrl.sv
// Simulation control block: test-good/done flags plus NCH delayed interrupt lines.
// Optional macro JTKCPU_SIMCTRL_LFSR_EN randomises each IRQ delay with a 16-bit LFSR.
module jtkcpu_simctrl #(
    parameter int NCH    = 3,
    parameter int DW     = 8,
    parameter int FINCNT = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen2,
    input  logic           cs,
    input  logic           we,
    input  logic [1:0]     addr,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic [NCH-1:0] irq_n,
    output logic           done,
    output logic           good
);
    localparam int FW = (FINCNT < 1) ? 1 : $clog2(FINCNT + 1);

    logic [NCH-1:0] r_req;
    logic [NCH-1:0] r_active;
    logic           r_armed;
    logic [DW-1:0]  r_cnt;
    logic [DW-1:0]  r_dly;
    logic           r_good;
    logic           r_done;
    logic           r_frun;
    logic [FW-1:0]  r_fcnt;
    logic           w_wr;
    logic           w_fire;
    logic [DW-1:0]  w_load;
    logic [7:0]     w_dout;

    assign w_wr   = cs & we & cen2;
    assign w_fire = r_armed && (r_cnt == {DW{1'b0}});

`ifdef JTKCPU_SIMCTRL_LFSR_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11, stepping with the bus clock enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else if (cen2) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_load = r_lfsr[DW-1:0] & r_dly;
`else
    assign w_load = r_dly;
`endif

    // Interrupt request/delay engine; active uses the pre-write req so clears land one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req    <= {NCH{1'b0}};
            r_active <= {NCH{1'b0}};
            r_armed  <= 1'b0;
            r_cnt    <= {DW{1'b0}};
            r_dly    <= {DW{1'b0}};
        end else if (cen2) begin
            r_active <= r_req & (r_active | {NCH{w_fire}});
            if (w_wr && addr == 2'd1) begin
                r_req   <= din[NCH-1:0];
                r_cnt   <= w_load;
                r_armed <= 1'b1;
            end else if (w_fire) begin
                r_armed <= 1'b0;
            end else if (r_armed) begin
                r_cnt <= r_cnt - DW'(1);
            end
            if (w_wr && addr == 2'd2) begin
                r_dly <= din[DW-1:0];
            end
        end
    end

    // Good flag and clk-rate finish countdown; done is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good <= 1'b0;
            r_done <= 1'b0;
            r_frun <= 1'b0;
            r_fcnt <= {FW{1'b0}};
        end else begin
            if (w_wr && addr == 2'd0) begin
                r_good <= din[1];
            end
            if (r_frun) begin
                if (r_fcnt == {FW{1'b0}}) begin
                    r_done <= 1'b1;
                    r_frun <= 1'b0;
                end else begin
                    r_fcnt <= r_fcnt - FW'(1);
                end
            end else if (w_wr && addr == 2'd0 && din[0] && !r_done) begin
                r_frun <= 1'b1;
                r_fcnt <= FW'(FINCNT);
            end
        end
    end

    // Combinational register read mux
    always_comb begin
        w_dout = 8'h00;
        if (cs) begin
            case (addr)
                2'd0:    w_dout = {6'b000000, r_good, r_done};
                2'd1:    w_dout[NCH-1:0] = r_req;
                2'd2:    w_dout[DW-1:0]  = r_dly;
                2'd3:    w_dout[NCH-1:0] = r_active;
                default: w_dout = 8'h00;
            endcase
        end else begin
            w_dout = 8'h00;
        end
    end

    assign dout  = w_dout;
    assign irq_n = ~r_active;
    assign done  = r_done;
    assign good  = r_good;

endmodule

// File: tb/tb_jtkcpu_simctrl.sv
// Directed bench for jtkcpu_simctrl: expected values are queued when stimulus is
// driven and popped when the matching DUT observation is taken.
module tb_jtkcpu_simctrl;
    logic       clk;
    logic       rst_n;
    logic       cen2;
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [2:0] irq_n;
    logic       done;
    logic       good;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] exp_q[$];

    jtkcpu_simctrl #(.NCH(3), .DW(8), .FINCNT(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen2  (cen2),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .irq_n (irq_n),
        .done  (done),
        .good  (good)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    // one idle clk then one clk edge with cen2 high
    task automatic tick();
        @(negedge clk); cen2 = 1'b0;
        @(negedge clk); cen2 = 1'b1;
        @(posedge clk); #1; cen2 = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); cen2 = 1'b0;
        @(negedge clk); cen2 = 1'b1; cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clk); #1; cen2 = 1'b0; cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        @(negedge clk); cs = 1'b1; we = 1'b0; addr = a;
        #1 v = dout;
        cs = 1'b0;
    endtask

    task automatic measure(input int line, output int n);
        n = 0;
        while (irq_n[line] !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_irq();
        wr(2'd1, 8'h00);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; cs = 1'b0; we = 1'b0; cen2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        int         n;
        int         t0;
        int         first;
        bit         distinct;

        rst_n = 1'b0; cen2 = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        push(32'h7); chk("rst_irq_n", 32'(irq_n));
        push(32'h0); chk("rst_done", 32'(done));
        push(32'h0); chk("rst_good", 32'(good));
        @(negedge clk); rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            push(32'h0); rd(2'(a), v); chk("rst_dout", 32'(v));
        end

        // delay of 5 on line 0
        wr(2'd2, 8'h05);
        addr = 2'd2; #1;
        push(32'h0); chk("dout_cs_low", 32'(dout));
        push(32'h5); rd(2'd2, v); chk("dly_readback", 32'(v));
        push(32'd6);
        wr(2'd1, 8'h01);
        measure(0, n);
        chk("dly5_latency", 32'(n));
        push(32'h3); chk("dly5_others", 32'(irq_n[2:1]));
        push(32'h1); rd(2'd1, v); chk("req_readback", 32'(v));
        push(32'h1); rd(2'd3, v); chk("active_readback", 32'(v));

        // zero delay, then drop line 1
        wr(2'd2, 8'h00);
        push(32'h4);
        wr(2'd1, 8'h03);
        tick();
        chk("dly0_both", 32'(irq_n));
        push(32'h4); push(32'h6);
        wr(2'd1, 8'h01);
        chk("clr_same_edge", 32'(irq_n));
        tick();
        chk("clr_next_edge", 32'(irq_n));

        // rewrite while line 0 active: line 1 waits the new delay, line 0 stays
        wr(2'd2, 8'h03);
        push(32'd4); push(32'h0);
        wr(2'd1, 8'h03);
        measure(1, n);
        chk("rearm_latency", 32'(n));
        chk("rearm_line0_kept", 32'(irq_n[0]));

        // delay distribution with DLY=0x0F
        wr(2'd2, 8'h0F);
        first = -1;
        distinct = 1'b0;
        for (int i = 0; i < 16; i++) begin
            clear_irq();
`ifdef JTKCPU_SIMCTRL_LFSR_EN
            push(32'h1);
`else
            push(32'd16);
`endif
            wr(2'd1, 8'h01);
            measure(0, n);
`ifdef JTKCPU_SIMCTRL_LFSR_EN
            chk("lfsr_range", 32'(n >= 1 && n <= 16));
`else
            chk("fixed_delay", 32'(n));
`endif
            if (first < 0) first = n;
            else if (n != first) distinct = 1'b1;
        end
`ifdef JTKCPU_SIMCTRL_LFSR_EN
        push(32'h1); chk("lfsr_distinct", 32'(distinct));
`else
        push(32'h0); chk("fixed_distinct", 32'(distinct));
`endif

        // finish countdown with good=1
        push(32'h0); push(32'h1); push(32'h1);
        wr(2'd0, 8'h03);
        t0 = cyc;
        while (cyc < t0 + 20) begin @(posedge clk); #1; end
        chk("fin_not_yet", 32'(done));
        @(posedge clk); #1;
        chk("fin_done", 32'(done));
        chk("fin_good", 32'(good));
        push(32'h3);
        wr(2'd0, 8'h03);
        rd(2'd0, v); chk("fin_sticky", 32'(v));
        push(32'h1);
        wr(2'd0, 8'h00);
        rd(2'd0, v); chk("fin_good_clear", 32'(v));

        // second start during countdown must not restart it
        do_reset();
        push(32'h0); push(32'h1); push(32'h0);
        wr(2'd0, 8'h03);
        t0 = cyc;
        repeat (3) @(posedge clk);
        wr(2'd0, 8'h01);
        while (cyc < t0 + 20) begin @(posedge clk); #1; end
        chk("restart_not_yet", 32'(done));
        @(posedge clk); #1;
        chk("restart_done", 32'(done));
        chk("restart_good", 32'(good));

        // reset abort mid-delay and mid-countdown
        do_reset();
        wr(2'd2, 8'hFF);
        wr(2'd1, 8'h04);
        repeat (10) tick();
        wr(2'd0, 8'h01);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        push(32'h7); chk("abort_irq_n", 32'(irq_n));
        push(32'h0); chk("abort_done", 32'(done));
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        push(32'h0); rd(2'd1, v); chk("abort_req", 32'(v));
        push(32'h0); rd(2'd2, v); chk("abort_dly", 32'(v));
        repeat (40) tick();
        push(32'h7); chk("abort_irq_after", 32'(irq_n));
        push(32'h0); chk("abort_done_after", 32'(done));

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtkcpu_simctrl.md
JTKCPU_SIMCTRL -- requirements
Module: jtkcpu_simctrl

Interface
REQ-001 The module SHALL have parameter NCH, default 3, setting the number of interrupt channels (1..8).
REQ-002 The module SHALL have parameter DW, default 8, setting the delay counter width (1..8).
REQ-003 The module SHALL have parameter FINCNT, default 20, setting the finish countdown in clk cycles.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port cen2, input, 1 bit: CPU bus clock enable.
REQ-007 The module SHALL have port cs, input, 1 bit: register chip select.
REQ-008 The module SHALL have port we, input, 1 bit: write strobe.
REQ-009 The module SHALL have port addr, input, 2 bits: register index.
REQ-010 The module SHALL have port din, input, 8 bits: write data.
REQ-011 The module SHALL have port dout, output, 8 bits: read data.
REQ-012 The module SHALL have port irq_n, output, NCH bits: interrupt lines, active-low.
REQ-013 The module SHALL have port done, output, 1 bit: simulation finished, sticky.
REQ-014 The module SHALL have port good, output, 1 bit: pass flag.

Function
REQ-015 Register writes SHALL occur only on a clk edge where cs, we and cen2 are all high.
- addr0 CTRL: bit1 loads good; bit0=1 starts the finish countdown.
- addr1 IRQ: din[NCH-1:0] loads the req register, loads cnt, and sets armed.
- addr2 DLY: din[DW-1:0] loads dly.
- addr3: writes ignored.
REQ-016 Reads SHALL be combinational with cs high.
- addr0 returns {6'b0, good, done}.
- addr1 returns req, zero-padded.
- addr2 returns dly, zero-padded.
- addr3 returns the active vector, zero-padded.
- dout SHALL be 0 when cs is low.
REQ-017 The counter load value on an IRQ write SHALL be dly (see REQ-028 for the LFSR option).
REQ-018 The delay counter SHALL step only on cen2 edges:
- while armed and cnt!=0, cnt decrements by one;
- fire = armed && cnt==0;
- on fire, armed clears.
REQ-019 On each cen2 edge, active[i] SHALL update to req[i] && (active[i] || fire).
REQ-020 irq_n[i] SHALL equal ~active[i].
REQ-021 Latency SHALL be as follows: an IRQ write at cen2 edge k with load value d asserts irq_n low after cen2 edge k+1+d.
REQ-022 Clearing req[i] SHALL deassert irq_n[i] after the next cen2 edge, with no delay.
REQ-023 An IRQ write while lines are active SHALL behave as follows:
- lines still requested stay active;
- newly requested lines wait for the new delay;
- the counter restarts.
REQ-024 A CTRL write with bit0=1 while idle SHALL load fcnt=FINCNT.
- fcnt decrements on every clk edge, independent of cen2.
- done sets on the edge after fcnt reaches 0 and holds until reset.
REQ-025 A CTRL bit0 write while the countdown is running or done is high SHALL be ignored; good SHALL still update.

Reset
REQ-026 While rst_n is low, the block SHALL hold: irq_n all ones; done, good, req, active, armed, cnt, dly and fcnt zero; finish idle.
REQ-027 Reset asserted mid-countdown or mid-delay SHALL abort the operation immediately, with no interrupt and no done.

Configuration
REQ-028 With macro JTKCPU_SIMCTRL_LFSR_EN defined:
- a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances each cen2 edge;
- the IRQ load value is lfsr[DW-1:0] & dly.
Without the macro, the LFSR is absent and the load value is dly.

Verification
REQ-029 Bench SHALL cover a delay check: write DLY=5, then IRQ=3'b001 -> irq_n[0] low exactly 6 cen2 edges after the write; other lines remain high.
REQ-030 Bench SHALL cover immediate clear: IRQ=3'b011 with DLY=0 -> both low after 1 cen2; then IRQ=3'b001 -> irq_n[1] high after 1 cen2 while irq_n[0] stays low.
REQ-031 Bench SHALL cover finish and good: CTRL=8'h03 -> done high 21 clk cycles later with good=1; a second CTRL=8'h01 during the countdown does not restart it; good reads 0 afterwards.
REQ-032 Bench SHALL cover reset abort: write DLY=8'hFF, IRQ=3'b100, assert rst_n low after 10 cen2 -> irq_n=3'b111 and dout at addr1 reads 0 after release.
REQ-033 Bench SHALL cover the LFSR option: with JTKCPU_SIMCTRL_LFSR_EN defined and DLY=8'h0F -> every measured delay is in 0..15 plus 1, and at least two distinct delays appear over 16 IRQ writes; without the macro all delays equal 16.
